// File: rtl/id_ex_hazard_if.sv
// Signal bundle between the ID/EX hazard controller (slave) and the pipeline datapath (master).
// HAZ_STATS_EN adds the three 32-bit statistics outputs.
interface id_ex_hazard_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STAT_W = 32;

  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rt;
  logic              idex_memread;
  logic [REG_W-1:0]  idex_rt;
  logic              ex_branch_taken;
  logic              ex_jump;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_hold;
  logic [1:0]        hz_state;
  logic              mem_timeout;
`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stat_lu;
  logic [STAT_W-1:0] stat_mem;
  logic [STAT_W-1:0] stat_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken, ex_jump, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, hz_state, mem_timeout,
    input  stat_lu, stat_mem, stat_flush
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken, ex_jump, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, hz_state, mem_timeout,
    output stat_lu, stat_mem, stat_flush
  );
`else
  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken, ex_jump, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, hz_state, mem_timeout
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken, ex_jump, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, hz_state, mem_timeout
  );
`endif
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX producer-side hazard control: load-use stall, EX redirect flush, memory-wait freeze + timeout.
// Optional HAZ_STATS_EN adds free-running lu/mem/flush cycle counters.
module id_ex_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned WAIT_CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_hazard_if.slave hz_if
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } hz_state_e;

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  pending_q, pending_d;
  logic                  timeout_q, timeout_d;

  logic xfer_c, redir_c, lu_c;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, idex_hold_c;

  // Register 0 is never a real destination, so idex_rt==0 can never hazard
  assign lu_c = hz_if.idex_memread && (hz_if.idex_rt != 5'd0) &&
                ((hz_if.idex_rt == hz_if.id_rs) ||
                 (hz_if.id_uses_rt && (hz_if.idex_rt == hz_if.id_rt)));
  assign xfer_c  = hz_if.ex_branch_taken | hz_if.ex_jump;
  assign redir_c = xfer_c | pending_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      pending_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state: records which cause won this cycle
  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = '0;
    pending_d  = pending_q;
    timeout_d  = timeout_q;
    if (hz_if.mem_busy) begin
      state_d    = ST_MEM_WAIT;
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
      pending_d  = pending_q | xfer_c;
    end else if (redir_c) begin
      state_d   = ST_FLUSH;
      pending_d = 1'b0;
    end else if (lu_c) begin
      state_d = ST_LU_STALL;
    end
    if (wait_cnt_d == WAIT_CNT_W'(MEM_TIMEOUT)) begin
      timeout_d = 1'b1;
    end
  end

  // Strobes are decoded straight from inputs so a hazard gates this cycle's writes
  always_comb begin
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    idex_hold_c   = 1'b0;
    if (!rst_n) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end else if (hz_if.mem_busy) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_hold_c  = 1'b1;
    end else if (redir_c) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (lu_c) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  assign hz_if.pc_write    = pc_write_c;
  assign hz_if.ifid_write  = ifid_write_c;
  assign hz_if.ifid_flush  = ifid_flush_c;
  assign hz_if.idex_bubble = idex_bubble_c;
  assign hz_if.idex_hold   = idex_hold_c;
  assign hz_if.hz_state    = 2'(state_q);
  assign hz_if.mem_timeout = timeout_q;

`ifdef HAZ_STATS_EN
  logic [31:0] stat_lu_q, stat_mem_q, stat_flush_q;

  // Cycle counters for the winning cause; wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu_q    <= '0;
      stat_mem_q   <= '0;
      stat_flush_q <= '0;
    end else begin
      if (hz_if.mem_busy)                         stat_mem_q   <= stat_mem_q + 32'd1;
      if (!hz_if.mem_busy && redir_c)             stat_flush_q <= stat_flush_q + 32'd1;
      if (!hz_if.mem_busy && !redir_c && lu_c)    stat_lu_q    <= stat_lu_q + 32'd1;
    end
  end

  assign hz_if.stat_lu    = stat_lu_q;
  assign hz_if.stat_mem   = stat_mem_q;
  assign hz_if.stat_flush = stat_flush_q;
`endif

`ifndef SYNTHESIS
  logic [4:0] lu_rt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_rt_q <= '0;
    end else if (!hz_if.mem_busy && !redir_c && lu_c) begin
      lu_rt_q <= hz_if.idex_rt;
    end
  end

  // The inserted bubble must have cleared the load, so the same lu cannot recur
  a_lu_twice: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_LU_STALL) && lu_c && (hz_if.idex_rt == lu_rt_q)));
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: cycle-level reference model plus directed scenario checks.
module tb_id_ex_hazard_ctrl;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_hazard_if hz_if ();

  id_ex_hazard_ctrl #(.MEM_TIMEOUT(TMO), .WAIT_CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz_if(hz_if)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: action chosen this cycle and the history it leaves behind
  int         m_run   = 0;
  bit         m_pend  = 1'b0;
  bit         m_tmo   = 1'b0;
  logic [1:0] m_cause = 2'd0;

  // Per action {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold}: issue, stall, freeze, redirect
  logic [4:0] act_tbl [4] = '{5'b11000, 5'b00010, 5'b00001, 5'b11110};

  function automatic bit model_lu();
    return hz_if.idex_memread && (hz_if.idex_rt != 5'd0) &&
           ((hz_if.idex_rt == hz_if.id_rs) || (hz_if.id_uses_rt && (hz_if.idex_rt == hz_if.id_rt)));
  endfunction

  function automatic int model_action();
    if (hz_if.mem_busy) return 2;
    if (hz_if.ex_branch_taken || hz_if.ex_jump || m_pend) return 3;
    if (model_lu()) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 0;
      m_pend  <= 1'b0;
      m_tmo   <= 1'b0;
      m_cause <= 2'd0;
    end else begin
      m_cause <= 2'(model_action());
      if (hz_if.mem_busy) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= int'(TMO)) m_tmo <= 1'b1;
        if (hz_if.ex_branch_taken || hz_if.ex_jump) m_pend <= 1'b1;
      end else begin
        m_run <= 0;
        if (model_action() == 3) m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    e = rst_n ? act_tbl[model_action()] : 5'b00010;
    chk1("m.pc_write",    hz_if.pc_write,    e[4]);
    chk1("m.ifid_write",  hz_if.ifid_write,  e[3]);
    chk1("m.ifid_flush",  hz_if.ifid_flush,  e[2]);
    chk1("m.idex_bubble", hz_if.idex_bubble, e[1]);
    chk1("m.idex_hold",   hz_if.idex_hold,   e[0]);
    chk2("m.hz_state",    hz_if.hz_state,    m_cause);
    chk1("m.mem_timeout", hz_if.mem_timeout, m_tmo);
  end

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] xrt,
                        input logic br, input logic jmp, input logic busy);
    hz_if.id_rs           = rs;
    hz_if.id_rt           = rt;
    hz_if.id_uses_rt      = uses;
    hz_if.idex_memread    = mr;
    hz_if.idex_rt         = xrt;
    hz_if.ex_branch_taken = br;
    hz_if.ex_jump         = jmp;
    hz_if.mem_busy        = busy;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("rst.bubble", hz_if.idex_bubble, 1'b1);
    chk1("rst.pc", hz_if.pc_write, 1'b0);
    chk2("rst.state", hz_if.hz_state, 2'd0);
    go();
    rst_n = 1'b1;

    set_in(8, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk1("idle.pc", hz_if.pc_write, 1'b1); go();

    // load-use on rs
    set_in(8, 0, 0, 1, 8, 0, 0, 0); @(negedge clk);
    chk1("lu_rs.pc", hz_if.pc_write, 1'b0);
    chk1("lu_rs.ifid", hz_if.ifid_write, 1'b0);
    chk1("lu_rs.bubble", hz_if.idex_bubble, 1'b1); go();
    set_in(8, 0, 0, 0, 8, 0, 0, 0); @(negedge clk);
    chk2("lu_rs.state", hz_if.hz_state, 2'd1);
    chk1("lu_rs.after_pc", hz_if.pc_write, 1'b1); go();

    // load-use on rt, then rt match ignored when rt is not a source
    set_in(3, 9, 1, 1, 9, 0, 0, 0); @(negedge clk);
    chk1("lu_rt.pc", hz_if.pc_write, 1'b0); go();
    set_in(3, 9, 1, 0, 9, 0, 0, 0); @(negedge clk);
    chk2("lu_rt.state", hz_if.hz_state, 2'd1); go();
    set_in(3, 9, 0, 1, 9, 0, 0, 0); @(negedge clk);
    chk1("rt_unused.pc", hz_if.pc_write, 1'b1);
    chk1("rt_unused.bubble", hz_if.idex_bubble, 1'b0); go();

    // r0 never hazards
    set_in(0, 0, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk1("r0.pc", hz_if.pc_write, 1'b1);
    chk2("r0.state", hz_if.hz_state, 2'd0); go();

    // branch wins over lu
    set_in(8, 0, 0, 1, 8, 1, 0, 0); @(negedge clk);
    chk1("br_lu.flush", hz_if.ifid_flush, 1'b1);
    chk1("br_lu.bubble", hz_if.idex_bubble, 1'b1);
    chk1("br_lu.pc", hz_if.pc_write, 1'b1); go();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk2("br_lu.state", hz_if.hz_state, 2'd3);
    chk1("br_lu.noflush", hz_if.ifid_flush, 1'b0); go();

    set_in(0, 0, 0, 0, 0, 0, 1, 0); @(negedge clk);
    chk1("jmp.flush", hz_if.ifid_flush, 1'b1); go();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk2("jmp.state", hz_if.hz_state, 2'd3); go();

    // short wait: no timeout, no flush on release
    for (int k = 1; k <= 3; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1); @(negedge clk);
      chk1("mw3.hold", hz_if.idex_hold, 1'b1);
      chk1("mw3.tmo", hz_if.mem_timeout, 1'b0); go();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk2("mw3.state", hz_if.hz_state, 2'd2);
    chk1("mw3.noflush", hz_if.ifid_flush, 1'b0); go();

    // timeout after the 4th consecutive wait cycle
    for (int k = 1; k <= 6; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1); @(negedge clk);
      chk1("mw6.hold", hz_if.idex_hold, 1'b1);
      chk1("mw6.tmo", hz_if.mem_timeout, k >= 5); go();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk1("mw6.sticky", hz_if.mem_timeout, 1'b1); go();

    // branch during freeze redirects after release
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 0, 0, 0, 0, k == 1, 0, 1); @(negedge clk);
      chk1("mwbr.hold", hz_if.idex_hold, 1'b1);
      chk1("mwbr.flush", hz_if.ifid_flush, 1'b0);
      chk1("mwbr.pc", hz_if.pc_write, 1'b0); go();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk1("mwbr.rel_flush", hz_if.ifid_flush, 1'b1);
    chk1("mwbr.rel_pc", hz_if.pc_write, 1'b1);
    chk2("mwbr.rel_state", hz_if.hz_state, 2'd2); go();
    @(negedge clk);
    chk2("mwbr.state", hz_if.hz_state, 2'd3);
    chk1("mwbr.tmo", hz_if.mem_timeout, 1'b1); go();

    // reset mid-wait drops the pending redirect
    set_in(0, 0, 0, 0, 0, 1, 0, 1); go();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rstw.bubble", hz_if.idex_bubble, 1'b1);
    chk1("rstw.pc", hz_if.pc_write, 1'b0);
    chk1("rstw.hold", hz_if.idex_hold, 1'b0);
    chk2("rstw.state", hz_if.hz_state, 2'd0);
    chk1("rstw.tmo", hz_if.mem_timeout, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); go();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rstw.noflush", hz_if.ifid_flush, 1'b0);
    chk1("rstw.pc_after", hz_if.pc_write, 1'b1); go();
    @(negedge clk);
    chk2("rstw.state_after", hz_if.hz_state, 2'd0);
    chk1("rstw.noflush2", hz_if.ifid_flush, 1'b0); go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
